// File: rtl/core_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and data ports, routing in-order responses.
// Define CORE_MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module core_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   instr_req_i,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_gnt_o,
    output logic                   instr_rvalid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,
    output logic                   instr_err_o,
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    output logic                   data_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i,
    output logic                   busy_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic SrcInstr = 1'b0;
    localparam logic SrcData  = 1'b1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                state_q, state_d;
    logic                  winner_q, winner, sel;
    logic                  hold_we_q;
    logic [BeWidth-1:0]    hold_be_q;
    logic [AddrWidth-1:0]  hold_addr_q;
    logic [DataWidth-1:0]  hold_wdata_q;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [MaxOutstanding-1:0] id_fifo_q;
    logic                  any_req, can_issue, handshake, pop, head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign any_req   = instr_req_i | data_req_i;
    // Compared against the registered count, so a same-cycle pop cannot unblock a full FIFO.
    assign can_issue = (count_q < CntWidth'(MaxOutstanding));
    assign handshake = mem_req_o & mem_gnt_i;

`ifdef CORE_MEM_ARB_RR_EN
    logic rr_q;

    always_comb begin
        sel = data_req_i;
        if (instr_req_i && data_req_i) begin
            sel = rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= SrcInstr;
        end else if (handshake) begin
            rr_q <= ~winner;
        end
    end
`else
    assign sel = data_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        winner    = sel;
        mem_req_o = 1'b0;
        if (state_q == StHold) begin
            winner    = winner_q;
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
                state_d = StIdle;
            end
        end else if (can_issue && any_req) begin
            mem_req_o = 1'b1;
            if (!mem_gnt_i) begin
                state_d = StHold;
            end
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (state_q == StHold) begin
                mem_we_o    = hold_we_q;
                mem_be_o    = hold_be_q;
                mem_addr_o  = hold_addr_q;
                mem_wdata_o = hold_wdata_q;
            end else if (winner == SrcData) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o = handshake & (winner == SrcInstr);
    assign data_gnt_o  = handshake & (winner == SrcData);

    // Responses with nothing outstanding are dropped here.
    assign pop  = mem_rvalid_i & (count_q != '0);
    assign head = id_fifo_q[rd_ptr_q];

    assign instr_rvalid_o = pop & (head == SrcInstr);
    assign data_rvalid_o  = pop & (head == SrcData);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;

    assign count_d = count_q + CntWidth'(handshake) - CntWidth'(pop);
    assign busy_o  = mem_req_o | (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            winner_q     <= SrcInstr;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            id_fifo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == StIdle && state_d == StHold) begin
                winner_q     <= winner;
                hold_we_q    <= mem_we_o;
                hold_be_q    <= mem_be_o;
                hold_addr_q  <= mem_addr_o;
                hold_wdata_q <= mem_wdata_o;
            end
            if (handshake) begin
                id_fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && mem_rvalid_i) begin
            assert (count_q != '0)
            else $warning("mem_rvalid_i with no outstanding transaction, response dropped");
        end
    end
`endif

endmodule
